// File: rtl/dot_acc.sv
// dot_acc: sequential dot-product accumulator built around array_mul.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start, len          start a job of len terms (sampled in IDLE only)
//   in_valid, in_ready  operand-pair handshake
//   a, b                8-bit unsigned operands
//   out_valid,out_ready result handshake
//   acc_out             accumulator register
//   overflow            sticky carry-out of the accumulator for this job
//
// array_mul: combinational 8x8 unsigned array multiplier (a*b -> p).

module array_mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  // One shifted partial-product row per multiplier bit, summed in order.
  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p + (16'(a) << i);
    end
  end
endmodule

module dot_acc #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_len_q;
  logic [7:0]         r_a_q;
  logic [7:0]         r_b_q;
  logic               r_v1;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [15:0]        w_prod;
  logic [ACC_W:0]     w_sum;
  logic               w_hs;
  logic               w_last;

  array_mul u_mul (
    .a (r_a_q),
    .b (r_b_q),
    .p (w_prod)
  );

  assign w_hs   = in_valid && (r_state == S_RUN);
  assign w_last = (r_cnt == (r_len_q - ONE));
  // Extra top bit captures the carry out of the accumulator.
  assign w_sum  = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_hs && w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (r_state == S_RUN);
    out_valid = (r_state == S_DONE);
    acc_out   = r_acc;
    overflow  = r_ovf;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_len_q <= '0;
      r_a_q   <= '0;
      r_b_q   <= '0;
      r_v1    <= 1'b0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      // The pending product is folded in whatever the state; v1 is always
      // clear in IDLE, so the start-clear below never competes with it.
      if (r_v1) begin
        r_acc <= w_sum[ACC_W-1:0];
        r_ovf <= r_ovf | w_sum[ACC_W];
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len_q <= len;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_v1    <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_a_q <= a;
            r_b_q <= b;
            r_v1  <= 1'b1;
            r_cnt <= r_cnt + ONE;
          end else begin
            r_v1  <= 1'b0;
          end
        end
        S_DRAIN: r_v1 <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_acc.sv
module tb_dot_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, overflow0;
  logic [23:0] acc_out0;
  logic        in_ready1, out_valid1, overflow1;
  logic [15:0] acc_out1;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dot_acc u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
    .out_valid(out_valid0), .out_ready(out_ready),
    .acc_out(acc_out0), .overflow(overflow0)
  );

  dot_acc #(.ACC_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready),
    .acc_out(acc_out1), .overflow(overflow1)
  );

  // Pulse start for one edge; returns on the negedge after that edge.
  task automatic do_start(input logic [7:0] l);
    @(negedge clk);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one pair from a negedge, wait for acceptance, return on the
  // negedge after the handshake edge with in_valid dropped.
  task automatic push(input logic [7:0] pa, input logic [7:0] pb);
    int t;
    t = 0;
    in_valid = 1'b1; a = pa; b = pb;
    while (!in_ready0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      tests++; errors++;
      $display("FAIL push_timeout: in_ready=%0b required 1", in_ready0);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({in_ready0, out_valid0, overflow0, acc_out0} !== 27'd0) begin
      errors++;
      $display("FAIL reset_async: rdy=%0b vld=%0b ovf=%0b acc=%0d required all 0",
               in_ready0, out_valid0, overflow0, acc_out0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({in_ready0, out_valid0, overflow0, acc_out0} !== 27'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b vld=%0b ovf=%0b acc=%0d required all 0",
               in_ready0, out_valid0, overflow0, acc_out0);
    end
  endtask

  task automatic test_basic();
    do_start(8'd3);
    tests++;
    if (in_ready0 !== 1'b1) begin
      errors++; $display("FAIL basic_ready_run: got %0b required 1", in_ready0);
    end
    push(8'd30, 8'd100);
    push(8'd255, 8'd255);
    push(8'd131, 8'd72);
    // DRAIN cycle
    tests++;
    if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: rdy=%0b vld=%0b required 0 0", in_ready0, out_valid0);
    end
    @(negedge clk);
    tests++;
    if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: vld=%0b rdy=%0b required 1 0", out_valid0, in_ready0);
    end
    tests++;
    if (acc_out0 !== 24'd77457 || overflow0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: acc=%0d ovf=%0b required 77457 0", acc_out0, overflow0);
    end
    tests++;
    if (acc_out1 !== 16'd11921 || overflow1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_sum16: acc=%0d ovf=%0b required 11921 1", acc_out1, overflow1);
    end
    release_result();
    tests++;
    if (out_valid0 !== 1'b0 || acc_out0 !== 24'd77457) begin
      errors++;
      $display("FAIL basic_after_release: vld=%0b acc=%0d required 0 77457", out_valid0, acc_out0);
    end
  endtask

  task automatic test_zero();
    do_start(8'd0);
    tests++;
    if (out_valid0 !== 1'b1 || acc_out0 !== 24'd0 || overflow0 !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: vld=%0b acc=%0d ovf=%0b required 1 0 0",
               out_valid0, acc_out0, overflow0);
    end
    release_result();
    do_start(8'd2);
    push(8'd0, 8'd74);
    push(8'd1, 8'd127);
    @(negedge clk);
    tests++;
    if (out_valid0 !== 1'b1 || acc_out0 !== 24'd127) begin
      errors++;
      $display("FAIL zero_operand: vld=%0b acc=%0d required 1 127", out_valid0, acc_out0);
    end
    release_result();
  endtask

  task automatic test_overflow();
    do_start(8'd2);
    push(8'd255, 8'd255);
    push(8'd255, 8'd255);
    @(negedge clk);
    tests++;
    if (out_valid1 !== 1'b1 || acc_out1 !== 16'd64514 || overflow1 !== 1'b1) begin
      errors++;
      $display("FAIL ovf16_sum: vld=%0b acc=%0d ovf=%0b required 1 64514 1",
               out_valid1, acc_out1, overflow1);
    end
    tests++;
    if (acc_out0 !== 24'd130050 || overflow0 !== 1'b0) begin
      errors++;
      $display("FAIL ovf24_sum: acc=%0d ovf=%0b required 130050 0", acc_out0, overflow0);
    end
    release_result();
    do_start(8'd1);
    push(8'd2, 8'd3);
    @(negedge clk);
    tests++;
    if (out_valid1 !== 1'b1 || acc_out1 !== 16'd6 || overflow1 !== 1'b0) begin
      errors++;
      $display("FAIL ovf16_next: vld=%0b acc=%0d ovf=%0b required 1 6 0",
               out_valid1, acc_out1, overflow1);
    end
    release_result();
  endtask

  task automatic test_handshake_stress();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [23:0] exp;
    int t;
    va = '{8'd200, 8'd99, 8'd7, 8'd255};
    vb = '{8'd17, 8'd250, 8'd8, 8'd1};
    exp = '0;
    for (int i = 0; i < 4; i++) exp = exp + 24'(va[i]) * 24'(vb[i]);
    do_start(8'd4);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(va[i], vb[i]);
      if (i == 0) begin
        // start during RUN must be ignored
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
      end
    end
    t = 0;
    while (!out_valid0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (out_valid0 !== 1'b1 || acc_out0 !== exp) begin
      errors++;
      $display("FAIL stress_sum: vld=%0b acc=%0d required 1 %0d", out_valid0, acc_out0, exp);
    end
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 8'd3;
      @(negedge clk);
      tests++;
      if (out_valid0 !== 1'b1 || acc_out0 !== exp) begin
        errors++;
        $display("FAIL stress_stall%0d: vld=%0b acc=%0d required 1 %0d",
                 i, out_valid0, acc_out0, exp);
      end
    end
    start = 1'b0;
    release_result();
    tests++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL stress_no_queue: vld=%0b rdy=%0b required 0 0", out_valid0, in_ready0);
    end
    @(negedge clk);
    tests++;
    if (in_ready0 !== 1'b0 || acc_out0 !== exp) begin
      errors++;
      $display("FAIL stress_idle_hold: rdy=%0b acc=%0d required 0 %0d", in_ready0, acc_out0, exp);
    end
  endtask

  task automatic test_reset_mid();
    do_start(8'd5);
    push(8'd10, 8'd10);
    push(8'd20, 8'd20);
    tests++;
    if (acc_out0 !== 24'd100 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_partial: acc=%0d rdy=%0b required 100 1", acc_out0, in_ready0);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready0, out_valid0, overflow0, acc_out0} !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%0b vld=%0b ovf=%0b acc=%0d required all 0",
               in_ready0, out_valid0, overflow0, acc_out0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_start(8'd1);
    push(8'd127, 8'd127);
    @(negedge clk);
    tests++;
    if (out_valid0 !== 1'b1 || acc_out0 !== 24'd16129 || overflow0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_fresh_job: vld=%0b acc=%0d ovf=%0b required 1 16129 0",
               out_valid0, acc_out0, overflow0);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_handshake_stress();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
